// File: rtl/div_iter_pkg.sv
// Shared types for the iterative divider.
//   div_state_e      : divider control states
//   DIV_DATA_WIDTH   : default operand/result width
//   uint32_t         : default-width data word
package div_iter_pkg;

   localparam int unsigned DIV_DATA_WIDTH = 32;

   typedef logic [DIV_DATA_WIDTH-1:0] uint32_t;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

endpackage : div_iter_pkg

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU (quotient -> LO, remainder -> HI).
// Latency from accept to div_done is DATA_WIDTH+1 cycles, independent of the operands.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               cancel in-flight op; blocks accept in IDLE
//   div_req             start request, sampled only in IDLE
//   div_signed          1 = DIV (two's complement), 0 = DIVU
//   dividend, divisor   operands, latched on accept
//   div_busy            high while iterating (execute stalls)
//   div_done            one-cycle pulse when quotient/remainder are updated
//   quotient, remainder results, held until the next completed op
module div_iter
   import div_iter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DIV_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  div_req,
   input  logic                  div_signed,
   input  logic [DATA_WIDTH-1:0] dividend,
   input  logic [DATA_WIDTH-1:0] divisor,
   output logic                  div_busy,
   output logic                  div_done,
   output logic [DATA_WIDTH-1:0] quotient,
   output logic [DATA_WIDTH-1:0] remainder
);

   localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   // Two's complement negate.
   function automatic logic [DATA_WIDTH-1:0] negate(input logic [DATA_WIDTH-1:0] x);
      return '0 - x;
   endfunction

   // Magnitude; the most negative value maps to itself read as unsigned.
   function automatic logic [DATA_WIDTH-1:0] abs_val(input logic [DATA_WIDTH-1:0] x,
                                                      input logic                  sgn);
      return (sgn && x[DATA_WIDTH-1]) ? negate(x) : x;
   endfunction

   // One restoring step: shift the next dividend bit into the DW+1 bit partial remainder,
   // subtract when it fits. Returns {next remainder, next dividend/quotient shift register}.
   function automatic logic [2*DATA_WIDTH-1:0] div_step(input logic [DATA_WIDTH-1:0] r,
                                                        input logic [DATA_WIDTH-1:0] q,
                                                        input logic [DATA_WIDTH-1:0] d);
      logic [DATA_WIDTH:0] sh;
      logic [DATA_WIDTH:0] dd;
      logic                qbit;
      sh   = {r, q[DATA_WIDTH-1]};
      dd   = {1'b0, d};
      qbit = (sh >= dd);
      if (qbit) sh = sh - dd;
      // After a step the remainder is below a non-zero divisor, so DW bits hold it;
      // with a zero divisor the truncation reproduces the dividend bits.
      return {sh[DATA_WIDTH-1:0], q[DATA_WIDTH-2:0], qbit};
   endfunction

   div_state_e            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q;
   logic [DATA_WIDTH-1:0] rem_q;     // partial remainder
   logic [DATA_WIDTH-1:0] shq_q;     // dividend bits shifting out, quotient bits shifting in
   logic [DATA_WIDTH-1:0] dvs_q;     // |divisor|
   logic                  q_neg_q;
   logic                  r_neg_q;
   logic                  dz_q;

   logic [DATA_WIDTH-1:0] step_r, step_q, q_fin, r_fin;

   // Iteration step, sign fix-up of the final step, and next-state decode.
   always_comb begin
      {step_r, step_q} = div_step(rem_q, shq_q, dvs_q);
      q_fin   = dz_q ? '1 : (q_neg_q ? negate(step_q) : step_q);
      r_fin   = r_neg_q ? negate(step_r) : step_r;
      state_d = state_q;
      case (state_q)
         DIV_IDLE: if (div_req && !flush) state_d = DIV_CALC;
         DIV_CALC: begin
            if (flush)                  state_d = DIV_IDLE;
            else if (cnt_q == CNT_LAST) state_d = DIV_DONE;
         end
         DIV_DONE: state_d = DIV_IDLE;
         default:  state_d = DIV_IDLE;
      endcase
   end

   // State, counter, datapath and registered outputs.
   // A flush in the final CALC cycle cancels the op before the done pulse is registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= DIV_IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         shq_q     <= '0;
         dvs_q     <= '0;
         q_neg_q   <= 1'b0;
         r_neg_q   <= 1'b0;
         dz_q      <= 1'b0;
         div_busy  <= 1'b0;
         div_done  <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
      end else begin
         state_q  <= state_d;
         div_done <= 1'b0;
         case (state_q)
            DIV_IDLE: begin
               if (div_req && !flush) begin
                  shq_q    <= abs_val(dividend, div_signed);
                  dvs_q    <= abs_val(divisor, div_signed);
                  rem_q    <= '0;
                  q_neg_q  <= div_signed && (dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1]);
                  r_neg_q  <= div_signed && dividend[DATA_WIDTH-1];
                  dz_q     <= (divisor == '0);
                  cnt_q    <= '0;
                  div_busy <= 1'b1;
               end
            end
            DIV_CALC: begin
               if (flush) begin
                  cnt_q    <= '0;
                  div_busy <= 1'b0;
               end else begin
                  rem_q <= step_r;
                  shq_q <= step_q;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_LAST) begin
                     div_busy  <= 1'b0;
                     div_done  <= 1'b1;
                     quotient  <= q_fin;
                     remainder <= r_fin;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule : div_iter

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: stimulus pushes expected {quotient, remainder, done cycle},
// a negedge monitor pops and compares on every div_done pulse.
module tb_div_iter;
   import div_iter_pkg::*;

   typedef struct {
      uint32_t     q;
      uint32_t     r;
      int unsigned cyc;
   } exp_t;

   logic    clk = 1'b0;
   logic    rst = 1'b1;
   logic    flush = 1'b0;
   logic    div_req = 1'b0;
   logic    div_signed = 1'b0;
   uint32_t dividend = '0;
   uint32_t divisor = '0;
   logic    div_busy, div_done;
   uint32_t quotient, remainder;

   int unsigned cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;
   exp_t        sb[$];

   div_iter dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .div_req   (div_req),
      .div_signed(div_signed),
      .dividend  (dividend),
      .divisor   (divisor),
      .div_busy  (div_busy),
      .div_done  (div_done),
      .quotient  (quotient),
      .remainder (remainder)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (div_done) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 expected no pulse (cyc %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("quotient", quotient, e.q);
            chk("remainder", remainder, e.r);
            chk("done_cycle", cyc, e.cyc);
         end
      end
   end

   // One op: req in cycle 0, operands scrambled after accept, done expected in cycle 33.
   task automatic run_op(input logic sgn, input uint32_t a, input uint32_t b,
                         input uint32_t eq, input uint32_t er);
      int busy_n;
      @(negedge clk);
      div_signed = sgn;
      dividend   = a;
      divisor    = b;
      div_req    = 1'b1;
      sb.push_back('{eq, er, cyc + 33});
      @(negedge clk);
      div_req  = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
      busy_n   = 0;
      for (int i = 1; i <= 33; i++) begin
         if (div_busy) busy_n++;
         @(negedge clk);
      end
      chk("busy_cycles", 32'(busy_n), 32'd32);
      chk("done_seen", 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   // Starts an op that will be cancelled; leaves the bench at the cycle-1 negedge.
   task automatic start_unchecked(input uint32_t a, input uint32_t b);
      @(negedge clk);
      div_signed = 1'b0;
      dividend   = a;
      divisor    = b;
      div_req    = 1'b1;
      @(negedge clk);
      div_req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(div_busy), 32'd0);
      chk("rst_done", 32'(div_done), 32'd0);
      chk("rst_quotient", quotient, 32'd0);
      chk("rst_remainder", remainder, 32'd0);
      rst = 1'b0;

      // Basic and signed cases
      run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
      run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
      run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
      run_op(1'b0, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1);
      run_op(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE);
      // Overflow wrap and its unsigned counterpart
      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
      run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
      // Divide by zero
      run_op(1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678);
      run_op(1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678);
      run_op(1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9);

      // Flush in CALC cycle 10: busy drops in cycle 11, no done, results held
      start_unchecked(32'd500, 32'd3);
      repeat (9) @(negedge clk);
      chk("busy_before_flush", 32'(div_busy), 32'd1);
      flush = 1'b1;
      div_req = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      div_req = 1'b0;
      chk("busy_after_flush", 32'(div_busy), 32'd0);
      repeat (30) @(negedge clk);
      chk("flush_keeps_q", quotient, 32'hFFFF_FFFF);
      chk("flush_keeps_r", remainder, 32'hFFFF_FFF9);
      run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);

      // Req held across an op with operands changed after accept; re-accept in cycle 34
      @(negedge clk);
      div_signed = 1'b0;
      dividend   = 32'd100;
      divisor    = 32'd7;
      div_req    = 1'b1;
      sb.push_back('{32'd14, 32'd2, cyc + 33});
      @(negedge clk);
      dividend = 32'd1000;
      divisor  = 32'd10;
      sb.push_back('{32'd100, 32'd0, cyc + 66});
      repeat (33) @(negedge clk);
      chk("idle_cycle34", 32'(div_busy), 32'd0);
      @(negedge clk);
      div_req = 1'b0;
      chk("reaccept_busy", 32'(div_busy), 32'd1);
      repeat (33) @(negedge clk);
      chk("held_req_drained", 32'(sb.size()), 32'd0);
      sb.delete();

      // Flush coinciding with the edge that would enter DONE: no pulse, results held
      start_unchecked(32'd50, 32'd5);
      repeat (31) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("late_flush_done", 32'(div_done), 32'd0);
      chk("late_flush_busy", 32'(div_busy), 32'd0);
      chk("late_flush_q", quotient, 32'd100);
      repeat (3) @(negedge clk);

      // Asynchronous reset mid-CALC clears outputs without waiting for an edge
      start_unchecked(32'd77, 32'd7);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("arst_busy", 32'(div_busy), 32'd0);
      chk("arst_done", 32'(div_done), 32'd0);
      chk("arst_quotient", quotient, 32'd0);
      chk("arst_remainder", remainder, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE);

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_div_iter
